// File: rtl/dmd_pkg.sv
// ============================================================================
// Module      : dmd_pkg
// Description : Shared constants and FSM state encoding for the DMD row-scan
//               controller (panel geometry, row index width, scan states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmd_pkg;

    localparam int DMD_ROWS = 16;
    localparam int DMD_COLS = 16;
    localparam int ROW_W    = $clog2(DMD_ROWS);

    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(DMD_ROWS - 1);

    // Scan FSM encoding
    typedef logic [2:0] dmd_state_t;
    localparam dmd_state_t c_st_idle   = 3'd0;
    localparam dmd_state_t c_st_blank  = 3'd1;
    localparam dmd_state_t c_st_load   = 3'd2;
    localparam dmd_state_t c_st_strobe = 3'd3;
    localparam dmd_state_t c_st_dwell  = 3'd4;

    // Larger of two cycle counts; sizes the shared blank/dwell counter
    function automatic int dmd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmd_scan_ctrl_if.sv
// ============================================================================
// Module      : dmd_scan_ctrl_if
// Description : Host-side write/control and panel-side drive signals of the
//               DMD scan controller. master = host/bench, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmd_scan_ctrl_if;
    import dmd_pkg::*;

    logic                enable;
    logic                wr_en;
    logic [ROW_W-1:0]    wr_row;
    logic [DMD_COLS-1:0] wr_data;
    logic                swap_req;
    logic                swap_ack;
    logic [ROW_W-1:0]    dmd_seg;
    logic [DMD_COLS-1:0] dmd_column;
    logic                DMD_CLK;
    logic                DMD_CLR;
    logic                frame_start;

    modport master (
        output enable, wr_en, wr_row, wr_data, swap_req,
        input  swap_ack, dmd_seg, dmd_column, DMD_CLK, DMD_CLR, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_row, wr_data, swap_req,
        output swap_ack, dmd_seg, dmd_column, DMD_CLK, DMD_CLR, frame_start
    );

endinterface

`default_nettype wire

// File: rtl/dmd_frame_buf.sv
// ============================================================================
// Module      : dmd_frame_buf
// Description : 1- or 2-bank 16x16 pixel register file. One synchronous write
//               port, one asynchronous row read port, explicit bank selects.
//               Synchronous reset clears every bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmd_frame_buf
    import dmd_pkg::*;
#(
    parameter int NUM_BANKS = 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                wr_en_i,
    input  wire logic                wr_bank_i,
    input  wire logic [ROW_W-1:0]    wr_row_i,
    input  wire logic [DMD_COLS-1:0] wr_data_i,
    input  wire logic                rd_bank_i,
    input  wire logic [ROW_W-1:0]    rd_row_i,
    output logic      [DMD_COLS-1:0] rd_data_o
);

    localparam int ADDR_W  = ROW_W + ((NUM_BANKS > 1) ? 1 : 0);
    localparam int DEPTH   = NUM_BANKS * DMD_ROWS;

    logic [DMD_COLS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;

    generate
        if (NUM_BANKS > 1) begin : g_banked
            assign wr_addr = {wr_bank_i, wr_row_i};
            assign rd_addr = {rd_bank_i, rd_row_i};
        end else begin : g_flat
            logic w_unused_bank;
            assign wr_addr       = wr_row_i;
            assign rd_addr       = rd_row_i;
            assign w_unused_bank = wr_bank_i ^ rd_bank_i;
        end
    endgenerate

    // Storage: cleared on reset, one row written per strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/dmd_scan_ctrl.sv
// ============================================================================
// Module      : dmd_scan_ctrl
// Description : Row-scan controller for a 16x16 DMD panel. Each row is blanked
//               for BLANK_CYCLES, loaded, strobed for one cycle and held for
//               DWELL_CYCLES. Frames always complete before the scan stops.
//               Optional macro DMD_DOUBLE_BUFFER_EN: front/back banks with a
//               swap at the frame boundary (or from IDLE); otherwise a single
//               bank written directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmd_scan_ctrl
    import dmd_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    dmd_scan_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(dmd_max(DWELL_CYCLES, BLANK_CYCLES) + 1);
    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [ROW_W-1:0] c_row_one    = ROW_W'(1);

    dmd_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    seg_q, seg_d;
    logic [DMD_COLS-1:0] col_q, col_d;
    logic                clr_q, clr_d;
    logic                strobe_q, strobe_d;
    logic                fs_q, fs_d;
    logic                ack_q, ack_d;

    logic                w_wr_bank;
    logic                w_rd_bank;
    logic [DMD_COLS-1:0] w_rd_data;
    logic [DMD_COLS-1:0] w_row_pixels;

`ifdef DMD_DOUBLE_BUFFER_EN
    localparam int c_banks = 2;
    logic bank_q, bank_d;
    logic w_frame_end;

    // Writes always target the hidden bank; the panel reads the front bank
    assign w_wr_bank    = ~bank_q;
    assign w_rd_bank    = bank_q;
    assign w_row_pixels = w_rd_data;
    assign w_frame_end  = (state_q == c_st_dwell) && (cnt_q == '0) &&
                          (row_q == c_row_last);

    // Swap at the frame boundary or straight from IDLE; the ack guard stops a
    // still-held request from swapping twice
    always_comb begin
        bank_d = bank_q;
        ack_d  = 1'b0;
        if (!ack_q && bus.swap_req && (w_frame_end || state_q == c_st_idle)) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
        end
    end

    // Front-bank select
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bank_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
        end
    end
`else
    localparam int c_banks = 1;
    logic swap_req_q;

    // Single bank: a write landing on the edge that enters LOAD is forwarded
    // so the row shows the buffer contents as they stand in the LOAD cycle
    assign w_wr_bank    = 1'b0;
    assign w_rd_bank    = 1'b0;
    assign w_row_pixels = (bus.wr_en && bus.wr_row == row_q) ? bus.wr_data
                                                              : w_rd_data;

    // Acknowledge the rising edge of a request; nothing to swap
    always_comb begin
        ack_d = bus.swap_req & ~swap_req_q;
    end

    // Request history for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            swap_req_q <= 1'b0;
        end else begin
            swap_req_q <= bus.swap_req;
        end
    end
`endif

    dmd_frame_buf #(
        .NUM_BANKS (c_banks)
    ) u_frame_buf (
        .clk       (CLK),
        .rst       (RESET),
        .wr_en_i   (bus.wr_en),
        .wr_bank_i (w_wr_bank),
        .wr_row_i  (bus.wr_row),
        .wr_data_i (bus.wr_data),
        .rd_bank_i (w_rd_bank),
        .rd_row_i  (row_q),
        .rd_data_o (w_rd_data)
    );

    // Scan sequencing: blank -> load -> strobe -> dwell per row, stop only at
    // the end of row 15
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            c_st_idle: begin
                row_d = '0;
                if (bus.enable) begin
                    state_d = c_st_blank;
                    cnt_d   = c_blank_last;
                end
            end
            c_st_blank: begin
                if (cnt_q == '0) begin
                    state_d = c_st_load;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            c_st_load: begin
                state_d = c_st_strobe;
            end
            c_st_strobe: begin
                state_d = c_st_dwell;
                cnt_d   = c_dwell_last;
            end
            c_st_dwell: begin
                if (cnt_q == '0) begin
                    row_d = row_q + c_row_one;
                    cnt_d = c_blank_last;
                    if (row_q == c_row_last && !bus.enable) begin
                        state_d = c_st_idle;
                    end else begin
                        state_d = c_st_blank;
                    end
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Panel outputs follow the state being entered so they register in step
    // with it; column data is frozen from LOAD to the end of DWELL
    always_comb begin
        clr_d    = (state_d == c_st_idle) || (state_d == c_st_blank);
        strobe_d = (state_d == c_st_strobe);
        fs_d     = (state_d == c_st_load) && (row_q == '0);
        seg_d    = seg_q;
        col_d    = col_q;
        if (state_d == c_st_idle) begin
            seg_d = '0;
            col_d = '0;
        end else if (state_d == c_st_blank) begin
            col_d = '0;
        end else if (state_d == c_st_load) begin
            seg_d = row_q;
            col_d = w_row_pixels;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= c_st_idle;
            cnt_q    <= '0;
            row_q    <= '0;
            seg_q    <= '0;
            col_q    <= '0;
            clr_q    <= 1'b1;
            strobe_q <= 1'b0;
            fs_q     <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            seg_q    <= seg_d;
            col_q    <= col_d;
            clr_q    <= clr_d;
            strobe_q <= strobe_d;
            fs_q     <= fs_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.swap_ack    = ack_q;
    assign bus.dmd_seg     = seg_q;
    assign bus.dmd_column  = col_q;
    assign bus.DMD_CLK     = strobe_q;
    assign bus.DMD_CLR     = clr_q;
    assign bus.frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_dmd_scan_ctrl.sv
// ============================================================================
// Module      : tb_dmd_scan_ctrl
// Description : Self-checking bench for dmd_scan_ctrl (DWELL=3, BLANK=2, row
//               period 7, frame 112). A position-in-frame model predicts every
//               output each cycle; directed scenarios add literal pins.
//               Honours DMD_DOUBLE_BUFFER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmd_scan_ctrl;
    import dmd_pkg::*;

    localparam int DW    = 3;
    localparam int BL    = 2;
    localparam int P     = BL + DW + 2;
    localparam int FRAME = 16 * P;

    logic CLK = 1'b0;
    logic RESET;

    dmd_scan_ctrl_if bus();

    dmd_scan_ctrl #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: scan position p counts cycles since the frame began
    bit          m_run;
    int          m_p;
    int          m_bank;
    logic        m_ack;
    logic        m_prevreq;
    logic [15:0] m_col;
    logic [15:0] m_mem [2][16];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    bit track  = 1'b0;
    int last_fs = -1;
    int n_fs   = 0;
    int n_a5   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step();
        bit boundary;
        if (RESET) begin
            m_run = 0; m_p = 0; m_bank = 0; m_ack = 0; m_prevreq = 0; m_col = '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 16; r++)
                    m_mem[b][r] = '0;
        end else begin
            boundary = m_run && (m_p == FRAME - 1);
`ifdef DMD_DOUBLE_BUFFER_EN
            if (bus.wr_en) m_mem[m_bank ^ 1][bus.wr_row] = bus.wr_data;
            if (!m_ack && bus.swap_req && (boundary || !m_run)) begin
                m_bank = m_bank ^ 1;
                m_ack  = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
`else
            if (bus.wr_en) m_mem[0][bus.wr_row] = bus.wr_data;
            m_ack     = bus.swap_req && !m_prevreq;
            m_prevreq = bus.swap_req;
`endif
            if (!m_run) begin
                if (bus.enable) begin m_run = 1; m_p = 0; end
            end else if (boundary) begin
                m_p = 0;
                if (!bus.enable) m_run = 0;
            end else begin
                m_p++;
            end
            if (!m_run) m_col = '0;
            else if (m_p % P < BL) m_col = '0;
            else if (m_p % P == BL) m_col = m_mem[m_bank][m_p / P];
        end
    endtask

    task automatic compare_all();
        int ph, rw;
        ph = m_p % P;
        rw = m_p / P;
        chk("DMD_CLR", 32'(bus.DMD_CLR), 32'(!m_run || ph < BL));
        chk("DMD_CLK", 32'(bus.DMD_CLK), 32'(m_run && ph == BL + 1));
        chk("frame_start", 32'(bus.frame_start), 32'(m_run && ph == BL && rw == 0));
        chk("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
        chk("dmd_column", 32'(bus.dmd_column), 32'(m_col));
        if (!m_run) chk("dmd_seg_idle", 32'(bus.dmd_seg), 32'(0));
        else if (ph >= BL) chk("dmd_seg", 32'(bus.dmd_seg), 32'(rw));
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cyc_n++;
        compare_all();
        if (track) begin
            if (bus.frame_start) begin
                if (last_fs >= 0) chk("fs_period", 32'(cyc_n - last_fs), 32'(FRAME));
                last_fs = cyc_n;
                n_fs++;
            end
            if (bus.DMD_CLK && bus.dmd_seg == 4'd5) begin
                chk("row5_col", 32'(bus.dmd_column), 32'h0000_A5A5);
                n_a5++;
            end
        end
    endtask

    task automatic wait_strobe(input int row);
        bit found = 0;
        for (int i = 0; i < FRAME + P && !found; i++) begin
            cyc();
            if (bus.DMD_CLK && bus.dmd_seg == 4'(row)) found = 1;
        end
        chk("strobe_found", 32'(found), 32'(1));
    endtask

    task automatic do_swap();
        bit got = 0;
        bus.swap_req = 1'b1;
        for (int i = 0; i < 5 && !got; i++) begin
            cyc();
            if (bus.swap_ack) got = 1;
        end
        bus.swap_req = 1'b0;
        chk("swap_ack_idle", 32'(got), 32'(1));
    endtask

    initial begin
        int n_clk, last_seg;
        RESET = 1'b1;
        bus.enable = 0; bus.wr_en = 0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 0;
        repeat (3) cyc();
        chk("rst_clr", 32'(bus.DMD_CLR), 32'(1));
        chk("rst_col", 32'(bus.dmd_column), 32'(0));
        chk("rst_seg", 32'(bus.dmd_seg), 32'(0));
        chk("rst_clk", 32'(bus.DMD_CLK), 32'(0));
        RESET = 1'b0;

        // Row 5 pattern, made visible, then two free-running frames
        bus.wr_en = 1; bus.wr_row = 4'd5; bus.wr_data = 16'hA5A5;
        cyc();
        bus.wr_en = 0;
        do_swap();
        bus.enable = 1;
        track = 1;
        repeat (2 * FRAME + 10) cyc();
        track = 0;
        chk("fs_count", 32'(n_fs), 32'(3));
        chk("row5_seen", 32'(n_a5), 32'(2));

        // Disable at row 7: rows 8..15 still strobe, then idle
        wait_strobe(7);
        bus.enable = 0;
        n_clk = 0; last_seg = -1;
        repeat (FRAME) begin
            cyc();
            if (bus.DMD_CLK) begin n_clk++; last_seg = int'(bus.dmd_seg); end
        end
        chk("tail_rows", 32'(n_clk), 32'(8));
        chk("tail_last_row", 32'(last_seg), 32'(15));
        chk("idle_clr", 32'(bus.DMD_CLR), 32'(1));
        chk("idle_col", 32'(bus.dmd_column), 32'(0));

`ifdef DMD_DOUBLE_BUFFER_EN
        begin
            bit acked = 0;
            int n_pre = 0, n_ack = 0, n_ff = 0;
            bus.enable = 1;
            for (int r = 0; r < 16; r++) begin
                bus.wr_en = 1; bus.wr_row = 4'(r); bus.wr_data = 16'hFFFF;
                cyc();
            end
            bus.wr_en = 0;
            wait_strobe(3);
            bus.swap_req = 1;
            for (int i = 0; i < FRAME + P && !acked; i++) begin
                cyc();
                if (bus.DMD_CLK && bus.dmd_column == 16'hFFFF) n_pre++;
                if (bus.swap_ack) acked = 1;
            end
            bus.swap_req = 0;
            chk("swap_boundary_ack", 32'(acked), 32'(1));
            chk("swap_first_row", 32'(bus.DMD_CLR), 32'(1));
            chk("pre_swap_ff", 32'(n_pre), 32'(0));
            repeat (FRAME) begin
                cyc();
                if (bus.swap_ack) n_ack++;
                if (bus.DMD_CLK && bus.dmd_column == 16'hFFFF) n_ff++;
            end
            chk("ack_single_pulse", 32'(n_ack), 32'(0));
            chk("post_swap_ff", 32'(n_ff), 32'(16));
        end
`else
        // Write the displayed row mid-dwell: held now, shown next frame
        bus.enable = 1;
        wait_strobe(4);
        cyc();
        bus.wr_en = 1; bus.wr_row = 4'd4; bus.wr_data = 16'h00FF;
        cyc();
        bus.wr_en = 0;
        chk("row4_hold", 32'(bus.dmd_column), 32'h0000_0000);
        wait_strobe(4);
        chk("row4_next", 32'(bus.dmd_column), 32'h0000_00FF);
`endif

        // Randomised traffic, including enable toggles, swaps and resets
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_row  = 4'($urandom_range(0, 15));
            bus.wr_data = 16'($urandom);
            if (bus.swap_req && bus.swap_ack) bus.swap_req = 0;
            else if (!bus.swap_req && $urandom_range(0, 149) == 0) bus.swap_req = 1;
            cyc();
        end
        RESET = 0; bus.wr_en = 0; bus.swap_req = 0; bus.enable = 1;

        // Reset during the row 9 strobe
        bus.wr_en = 1; bus.wr_row = 4'd5; bus.wr_data = 16'hA5A5;
        cyc();
        bus.wr_en = 0;
        wait_strobe(9);
        RESET = 1;
        cyc();
        chk("rst37_clk", 32'(bus.DMD_CLK), 32'(0));
        chk("rst37_clr", 32'(bus.DMD_CLR), 32'(1));
        chk("rst37_seg", 32'(bus.dmd_seg), 32'(0));
        chk("rst37_col", 32'(bus.dmd_column), 32'(0));
        RESET = 0;
        wait_strobe(5);
        chk("rst37_buf_cleared", 32'(bus.dmd_column), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
